fp16_result_uart_tx: RTL
========================

FP16_RESULT_UART_TX -- requirements
Module: fp16_result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port result_in  input  16  FP16 result word from the calculator.
REQ-005 SHALL have port send  input  1  transmit request, level-sampled only in IDLE.
REQ-006 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-007 SHALL have port busy  output  1  high while a two-byte transmission is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking completion of both bytes.

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP, plus a 1-bit byte index (0 = high byte, 1 = low byte).
REQ-010 In IDLE with send=1 at a rising edge, SHALL capture result_in into a 16-bit shadow register, clear byte index and counters, and enter START on that same edge.
REQ-011 SHALL drive tx from a register: 0 in START, current data bit in DATA, 1 in STOP and IDLE; no combinational path from inputs to tx.
REQ-012 Each bit SHALL occupy exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that reloads at every bit boundary.
REQ-013 Byte 0 SHALL be shadow[15:8], byte 1 shadow[7:0]; bits within a byte SHALL be sent LSB first (d0..d7).
REQ-014 Frame per byte: 1 start bit, 8 data bits, 1 stop bit; after byte 0's stop bit SHALL go directly to START of byte 1 with no idle gap.
REQ-015 After byte 1's stop bit SHALL return to IDLE; total tx activity = 20*CLKS_PER_BIT cycles.
REQ-016 busy SHALL be 1 in every non-IDLE state, i.e. exactly 20*CLKS_PER_BIT cycles per transmission, starting the cycle after the capturing edge.
REQ-017 done SHALL be 1 for exactly the first IDLE cycle following byte 1's stop bit, coincident with busy falling; 0 otherwise.
REQ-018 send while busy=1 SHALL be ignored (no queueing); result_in changes while busy=1 SHALL not affect tx.
REQ-019 send=1 in the same cycle done=1 SHALL start a new transmission on that edge (minimum gap between frames: one idle-high cycle).
REQ-020 send held high continuously SHALL produce back-to-back transmissions, each re-sampling result_in at its start.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for clk, force tx=1, busy=0, done=0, state IDLE, byte index 0, baud and bit counters 0, shadow register 0x0000.
REQ-022 Reset mid-transmission SHALL abort the frame; after release the block SHALL remain idle until a new send and never emit done for the aborted frame.
REQ-023 Outputs SHALL hold reset values while reset=0 regardless of send.

Verification (CLKS_PER_BIT=4 unless noted; cycle 0 = capturing edge)
REQ-024 Hold reset=0, toggle send -> tx=1, busy=0, done=0 throughout, without clock dependence.
REQ-025 result_in=0x3C00, send pulsed one cycle -> tx bits (4 cycles each) 0,0,0,1,1,1,1,0,0,1 then 0,0,0,0,0,0,0,0,0,1; busy high cycles 1..80; done high only at cycle 81.
REQ-026 During scenario REQ-025, send=1 with result_in=0xFFFF at cycle 30 -> tx sequence unchanged, no extra done.
REQ-027 During scenario REQ-025, reset=0 at cycle 40 for 3 cycles -> tx=1 and busy=0 immediately; no done afterwards; tx stays 1 until next send.
REQ-028 send held high, result_in=0xC500 -> done pulses every 81 cycles, each frame starts with start bit the cycle after done; byte 0 = 0xC5 (bits 1,0,1,0,0,0,1,1).
REQ-029 CLKS_PER_BIT=2, result_in=0xA55A -> byte values 0xA5 then 0x5A decoded by bench UART receiver; busy exactly 40 cycles.

Source files
------------

// File: rtl/fp16_result_uart_tx_if.sv
// Handshake bundle between the FP16 calculator and its result UART transmitter.
interface fp16_result_uart_tx_if;
    logic [15:0] result_in;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output result_in,
        output send,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  result_in,
        input  send,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/fp16_result_uart_tx.sv
// Sends a captured 16-bit FP16 result as two back-to-back 8N1 UART bytes,
// high byte first, each byte LSB first.
module fp16_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    fp16_result_uart_tx_if.slave bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [15:0]       shadow;
    logic              byte_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        cur_byte;
    logic              bit_end;

    assign cur_byte = byte_idx ? shadow[7:0] : shadow[15:8];
    assign bit_end  = (baud_cnt == BAUD_LAST);

    // tx, busy and done are registered so the line never glitches from inputs;
    // each output is set one edge ahead of the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shadow   <= 16'h0000;
            byte_idx <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            bus.tx   <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                bus.tx   <= 1'b1;
                bus.busy <= 1'b0;
                if (bus.send) begin
                    shadow   <= bus.result_in;
                    byte_idx <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= 3'd0;
                    bus.tx   <= 1'b0;
                    bus.busy <= 1'b1;
                    state    <= START;
                end
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        bit_cnt <= 3'd0;
                        bus.tx  <= cur_byte[0];
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bus.tx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            bus.tx  <= cur_byte[bit_cnt + 3'd1];
                        end
                    end
                    STOP: begin
                        if (!byte_idx) begin
                            // Low byte follows immediately, no idle gap.
                            byte_idx <= 1'b1;
                            bus.tx   <= 1'b0;
                            state    <= START;
                        end else begin
                            bus.tx   <= 1'b1;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        bus.tx   <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
